mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative multiply/divide unit for the single-cycle MIPS datapath, sitting directly downstream of the register file read ports. It takes rs/rt operands (read_data_1/read_data_2) on a start strobe, computes MULT/MULTU/DIV/DIVU over 33 clocks, and holds the 64-bit result in architectural HI/LO registers. HI/LO feed the writeback mux for MFHI/MFLO. The control unit stalls on `busy`.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  launch operation selected by `op`; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_a  input  32  rs value (multiplicand / dividend)
- operand_b  input  32  rt value (multiplier / divisor)
- mthi  input  1  write `mt_data` to HI (MTHI)
- mtlo  input  1  write `mt_data` to LO (MTLO)
- mt_data  input  32  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse; HI/LO updated
- hi  output  32  HI register
- lo  output  32  LO register
- div_by_zero  output  1  last DIV/DIVU had divisor 0; held until the next accepted start

## Operation
- Single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset has priority over all other inputs, including mid-operation. It forces state IDLE, hi=0, lo=0, busy=0, done=0 and div_by_zero=0. Any in-flight result is discarded.
- States: IDLE, RUN, SIGN.
  - IDLE→RUN: on `start`. The unit latches operands and op, and converts the magnitudes for the signed ops (MULT, DIV). It clears div_by_zero and loads the iteration counter with 31.
  - RUN: one radix-2 step per cycle. Multiply is shift-add; divide is restoring shift-subtract. The counter decrements each cycle. RUN→SIGN when the counter is 0 after its step, which gives 32 steps.
  - SIGN→IDLE: the unit applies sign correction and writes HI/LO. It sets done=1 and busy=0.
- Arithmetic:
  - MULT and MULTU: {hi,lo} = full 64-bit signed or unsigned product.
  - DIV and DIVU: lo = quotient and hi = remainder, both truncated toward zero. The remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural wrap with no trap.
  - Divisor 0: the unit runs the full latency and leaves hi/lo unchanged. It sets div_by_zero=1 together with done.
- `start` while busy is ignored and does not restart the operation.
- mthi/mtlo:
  - In IDLE with no start, the write takes effect at the edge.
  - They are ignored while busy, and ignored on the same edge as an accepted start (start wins).
  - mthi and mtlo together write both registers.
- hi/lo change only on reset, a SIGN cycle or an MT write. They are stable during RUN.

## Timing
- Edge 0 (start accepted): busy=1 from this edge.
- Edges 1–32: RUN steps.
- Edge 33: SIGN. hi/lo are valid, done=1 and busy=0.
- Edge 34: done=0.
- Result latency is 33 cycles from the start edge.
- A new start is accepted on edge 34 at the earliest. Back-to-back throughput is one op per 34 cycles.
- The state after a start on the same edge as done low is IDLE, so there is no overlap.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are supported as above.
- `MDU_DIV_EN` undefined: the divider datapath is compiled out.
  - A start with op[1]=1 is ignored: busy stays 0, done is never pulsed, and hi/lo are unchanged.
  - div_by_zero is tied to 0.
  - MULT/MULTU behaviour and timing are identical to the defined case.

## Test plan
- MULT a=0x000000A5, b=0xFFFFFF5A → after 33 cycles hi=0xFFFFFFFF, lo=0xFFFF9502. done pulses exactly one cycle, and busy is high for edges 0–32.
- MULTU with the same operands → hi=0x000000A4, lo=0xFFFF9502.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 → lo=14, hi=2.
- DIV by zero:
  - Preload hi=0x11111111 and lo=0x22222222 via mthi/mtlo, then start DIVU a=5, b=0 → hi/lo unchanged, div_by_zero=1 with done.
  - Start a MULT next → div_by_zero clears on the start edge.
- Busy interactions, while MULT 3×4 runs: assert start with DIV, and assert mthi with 0xDEAD → both are ignored, and the result is hi=0, lo=12 at edge 33.
- Reset mid-operation: assert reset at RUN step 10 → the next cycle shows busy=0, done=0, hi=lo=0, and no done pulse follows. A fresh start afterwards completes normally. With `MDU_DIV_EN` undefined, a DIV start leaves busy=0 and no done.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Handshake and result bus of the iterative multiply/divide unit.
// The master side is the control unit / register file, the slave side is the unit.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] mt_data;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, operand_a, operand_b, mthi, mtlo, mt_data,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, operand_a, operand_b, mthi, mtlo, mt_data,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One radix-2 step per clock: shift-add multiply, restoring shift-subtract divide,
// operating on magnitudes with the sign fixed up in a final SIGN cycle.
// Build option: define MDU_DIV_EN to include the divider; without it DIV/DIVU
// starts are ignored and div_by_zero is tied low.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            reset,
   mult_div_unit_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      SIGN = 2'd2
   } state_t;

   state_t state, state_nxt;

   // control
   logic             accept, step, finish, mt_wr, op_ok;
   logic [CNT_W-1:0] cnt;
   logic             busy_r, done_r;
   logic [WIDTH-1:0] hi_r, lo_r;

   // datapath: acc_hi is the running partial product / partial remainder,
   // acc_lo holds multiplier bits (shifted out) or dividend/quotient bits
   logic signed [WIDTH-1:0] a_s, b_s;
   logic                    signed_op;
   logic [WIDTH-1:0]        mag_b_r;
   logic [WIDTH:0]          acc_hi;
   logic [WIDTH-1:0]        acc_lo;
   logic                    neg_lo_r;
   logic [WIDTH:0]          mul_sum;
   logic [WIDTH:0]          mul_hi_nxt;
   logic [WIDTH-1:0]        mul_lo_nxt;
   logic [2*WIDTH-1:0]      prod_res;
`ifdef MDU_DIV_EN
   logic                    is_div_r, neg_hi_r, div_zero_r, dbz_r;
   logic [WIDTH:0]          div_shift, div_trial, div_hi_nxt;
   logic [WIDTH-1:0]        div_lo_nxt, quot_res, rem_res;
`endif

   // Absolute value of an operand when the op is signed; raw bits otherwise.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic is_signed);
      logic [WIDTH-1:0] u;
      u = v;
      return (is_signed && (v < 0)) ? (~u + WIDTH'(1)) : u;
   endfunction

   // Two's-complement negate of a single word when en is set.
   function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic en);
      return en ? (~v + WIDTH'(1)) : v;
   endfunction

   // Two's-complement negate of the double-width product when en is set.
   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic en);
      return en ? (~v + (2*WIDTH)'(1)) : v;
   endfunction

   assign a_s       = bus.operand_a;
   assign b_s       = bus.operand_b;
   assign signed_op = ~bus.op[0];

`ifdef MDU_DIV_EN
   assign op_ok = 1'b1;
`else
   assign op_ok = ~bus.op[1];
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      mt_wr     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && op_ok) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               mt_wr = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == '0) state_nxt = SIGN;
         end
         SIGN: begin
            finish    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One radix-2 step for each algorithm plus the sign-corrected results.
   always_comb begin
      mul_sum    = acc_hi + (acc_lo[0] ? {1'b0, mag_b_r} : '0);
      mul_hi_nxt = {1'b0, mul_sum[WIDTH:1]};
      mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
      prod_res   = cond_neg_2w({acc_hi[WIDTH-1:0], acc_lo}, neg_lo_r);
`ifdef MDU_DIV_EN
      div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, mag_b_r};
      if (!div_trial[WIDTH]) begin
         div_hi_nxt = div_trial;
         div_lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         div_hi_nxt = div_shift;
         div_lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
      end
      quot_res = cond_neg_w(acc_lo, neg_lo_r);
      rem_res  = cond_neg_w(acc_hi[WIDTH-1:0], neg_hi_r);
`endif
   end

   // Datapath registers: load magnitudes on start, then iterate.
   always_ff @(posedge clk) begin
      if (accept) begin
         mag_b_r  <= magnitude(b_s, signed_op);
         acc_hi   <= '0;
         acc_lo   <= magnitude(a_s, signed_op);
         neg_lo_r <= signed_op & (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
`ifdef MDU_DIV_EN
         is_div_r   <= bus.op[1];
         neg_hi_r   <= signed_op & a_s[WIDTH-1];
         div_zero_r <= (bus.operand_b == '0);
`endif
      end else if (step) begin
`ifdef MDU_DIV_EN
         if (is_div_r) begin
            acc_hi <= div_hi_nxt;
            acc_lo <= div_lo_nxt;
         end else begin
            acc_hi <= mul_hi_nxt;
            acc_lo <= mul_lo_nxt;
         end
`else
         acc_hi <= mul_hi_nxt;
         acc_lo <= mul_lo_nxt;
`endif
      end
   end

   // Iteration counter, status flags and the architectural HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
`ifdef MDU_DIV_EN
         dbz_r  <= 1'b0;
`endif
      end else begin
         done_r <= finish;
         if (accept) begin
            busy_r <= 1'b1;
            cnt    <= CNT_W'(WIDTH - 1);
`ifdef MDU_DIV_EN
            dbz_r  <= 1'b0;
`endif
         end else if (step) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (finish) begin
            busy_r <= 1'b0;
`ifdef MDU_DIV_EN
            if (is_div_r) begin
               if (div_zero_r) begin
                  dbz_r <= 1'b1;
               end else begin
                  hi_r <= rem_res;
                  lo_r <= quot_res;
               end
            end else begin
               {hi_r, lo_r} <= prod_res;
            end
`else
            {hi_r, lo_r} <= prod_res;
`endif
         end
         if (mt_wr) begin
            if (bus.mthi) hi_r <= bus.mt_data;
            if (bus.mtlo) lo_r <= bus.mt_data;
         end
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;
`ifdef MDU_DIV_EN
   assign bus.div_by_zero = dbz_r;
`else
   assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: fixed vector table, hand-written timing and
// corner sequences, and randomized ops against a plain-arithmetic model.
module tb_mult_div_unit;

`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   // reference state: architectural HI/LO and the divide-by-zero flag
   logic [31:0] m_hi, m_lo;
   logic        m_dbz;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Expected effect of an op, straight from the arithmetic definitions.
   task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output bit fires);
      longint      sa, sb, q, r;
      logic [63:0] p;
      fires = 1'b1;
      if (op[1] && !DIV_EN) begin
         fires = 1'b0;
         return;
      end
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      p     = {m_hi, m_lo};
      m_dbz = 1'b0;
      case (op)
         2'b00: p = 64'(sa * sb);
         2'b01: p = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) m_dbz = 1'b1;
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) m_dbz = 1'b1;
            else begin
               q = longint'({32'd0, a} / {32'd0, b});
               r = longint'({32'd0, a} % {32'd0, b});
               p = {r[31:0], q[31:0]};
            end
         end
      endcase
      {m_hi, m_lo} = p;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Edges after the start edge until done is seen; -1 if none within the budget.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
      @(negedge clk);
      bus.mthi    = whi;
      bus.mtlo    = wlo;
      bus.mt_data = d;
      @(posedge clk);
      #1;
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      if (whi) m_hi = d;
      if (wlo) m_lo = d;
   endtask

   task automatic run_and_check(input string name, input logic [1:0] op,
                                input logic [31:0] a, input logic [31:0] b);
      bit fires;
      int lat;
      model_op(op, a, b, fires);
      issue(op, a, b);
      wait_done(lat);
      check({name, ".lat"}, 64'(lat), fires ? 64'd33 : 64'hFFFF_FFFF_FFFF_FFFF);
      check({name, ".hi"}, {32'd0, bus.hi}, {32'd0, m_hi});
      check({name, ".lo"}, {32'd0, bus.lo}, {32'd0, m_lo});
      check({name, ".dbz"}, {63'd0, bus.div_by_zero}, {63'd0, m_dbz});
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, err;
      bit          fires;
      logic [31:0] hold_hi, hold_lo, exp_hi, exp_lo;

      tbl[0] = '{2'b00, 32'h0000_00A5, 32'hFFFF_FF5A, 32'hFFFF_FFFF, 32'hFFFF_9502};
      tbl[1] = '{2'b01, 32'h0000_00A5, 32'hFFFF_FF5A, 32'h0000_00A4, 32'hFFFF_9502};
      tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
      tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      tbl[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      tbl[6] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      tbl[8] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
      tbl[9] = '{2'b11, 32'hFFFF_FFFF, 32'd10,        32'd5,         32'h1999_9999};

      bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
      bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = '0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;

      // reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", {63'd0, bus.busy}, 64'd0);
      check("rst.done", {63'd0, bus.done}, 64'd0);
      check("rst.hi", {32'd0, bus.hi}, 64'd0);
      check("rst.lo", {32'd0, bus.lo}, 64'd0);
      check("rst.dbz", {63'd0, bus.div_by_zero}, 64'd0);
      reset = 1'b0;

      // table of fixed vectors
      for (int i = 0; i < 10; i++) begin
         hold_hi = m_hi;
         hold_lo = m_lo;
         model_op(tbl[i].op, tbl[i].a, tbl[i].b, fires);
         exp_hi = fires ? tbl[i].hi : hold_hi;
         exp_lo = fires ? tbl[i].lo : hold_lo;
         issue(tbl[i].op, tbl[i].a, tbl[i].b);
         wait_done(lat);
         check($sformatf("tbl%0d.lat", i), 64'(lat), fires ? 64'd33 : 64'hFFFF_FFFF_FFFF_FFFF);
         check($sformatf("tbl%0d.hi", i), {32'd0, bus.hi}, {32'd0, exp_hi});
         check($sformatf("tbl%0d.lo", i), {32'd0, bus.lo}, {32'd0, exp_lo});
         check($sformatf("tbl%0d.busy", i), {63'd0, bus.busy}, 64'd0);
      end

      // exact busy/done timing, HI/LO stable during RUN, earliest back-to-back start
      mt_write(1'b1, 1'b1, 32'hAAAA_5555);
      check("mtboth.hi", {32'd0, bus.hi}, 64'h0000_0000_AAAA_5555);
      check("mtboth.lo", {32'd0, bus.lo}, 64'h0000_0000_AAAA_5555);
      issue(2'b00, 32'h0000_00A5, 32'hFFFF_FF5A);
      check("tim.e0.busy", {63'd0, bus.busy}, 64'd1);
      check("tim.e0.done", {63'd0, bus.done}, 64'd0);
      err = 0;
      for (int n = 1; n <= 32; n++) begin
         @(posedge clk);
         #1;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0 ||
             bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'hAAAA_5555) err++;
      end
      check("tim.run_window_errs", 64'(err), 64'd0);
      @(posedge clk);
      #1;
      check("tim.e33.done", {63'd0, bus.done}, 64'd1);
      check("tim.e33.busy", {63'd0, bus.busy}, 64'd0);
      check("tim.e33.hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_9502);
      bus.start = 1'b1; bus.op = 2'b01;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("tim.e34.done", {63'd0, bus.done}, 64'd0);
      check("tim.e34.busy", {63'd0, bus.busy}, 64'd1);
      wait_done(lat);
      check("b2b.lat", 64'(lat), 64'd33);
      check("b2b.hilo", {bus.hi, bus.lo}, 64'h0000_00A4_FFFF_9502);
      m_hi = 32'h0000_00A4; m_lo = 32'hFFFF_9502;

      // divide by zero leaves HI/LO and flags; next start clears the flag
      mt_write(1'b1, 1'b0, 32'h1111_1111);
      mt_write(1'b0, 1'b1, 32'h2222_2222);
      check("pre.hi", {32'd0, bus.hi}, 64'h0000_0000_1111_1111);
      check("pre.lo", {32'd0, bus.lo}, 64'h0000_0000_2222_2222);
      run_and_check("dbz", 2'b11, 32'd5, 32'd0);
      model_op(2'b00, 32'd3, 32'd3, fires);
      issue(2'b00, 32'd3, 32'd3);
      check("dbz.clear_on_start", {63'd0, bus.div_by_zero}, 64'd0);
      wait_done(lat);
      check("after_dbz.hilo", {bus.hi, bus.lo}, 64'd9);

      // start and mthi while busy are ignored
      hold_hi = bus.hi;
      issue(2'b00, 32'd3, 32'd4);
      lat = -1;
      err = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            lat = n;
            break;
         end
         if (bus.hi !== hold_hi) err++;
         if (n == 4) begin
            bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 32'd1; bus.operand_b = 32'd1;
            bus.mthi = 1'b1; bus.mt_data = 32'h0000_DEAD;
         end else if (n == 7) begin
            bus.start = 1'b0; bus.mthi = 1'b0;
         end
      end
      check("busy_ign.lat", 64'(lat), 64'd33);
      check("busy_ign.hi_stable", 64'(err), 64'd0);
      check("busy_ign.hilo", {bus.hi, bus.lo}, 64'd12);
      m_hi = 32'd0; m_lo = 32'd12;

      // start wins over MT write on the same edge
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
      bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h0000_BEEF;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
      check("samedge.hi", {32'd0, bus.hi}, 64'd0);
      check("samedge.lo", {32'd0, bus.lo}, 64'd12);
      wait_done(lat);
      check("samedge.hilo", {bus.hi, bus.lo}, 64'd6);
      m_hi = 32'd0; m_lo = 32'd6;

      // reset in the middle of RUN
      mt_write(1'b1, 1'b1, 32'hCAFE_F00D);
      issue(2'b00, 32'd7, 32'd9);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst.busy", {63'd0, bus.busy}, 64'd0);
      check("midrst.done", {63'd0, bus.done}, 64'd0);
      check("midrst.hilo", {bus.hi, bus.lo}, 64'd0);
      wait_done(lat);
      check("midrst.no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      run_and_check("postrst", 2'b01, 32'd7, 32'd9);

      // randomized ops and MT writes against the model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            logic [1:0] w;
            w = 2'($urandom_range(1, 3));
            mt_write(w[1], w[0], $urandom);
            check($sformatf("rnd%0d.mt.hi", i), {32'd0, bus.hi}, {32'd0, m_hi});
            check($sformatf("rnd%0d.mt.lo", i), {32'd0, bus.lo}, {32'd0, m_lo});
         end else begin
            run_and_check($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), pick_val(), pick_val());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
